hex_scan_display: RTL and testbench
===================================

HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DIGITS  8      number of 7-segment digits scanned (1..8)
  DIV     50000  clk_50m cycles a digit is lit per slot (>=1)
  GUARD   16     all-off cycles before each slot, anti-ghosting (>=1)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk_50m   in   1          system clock, 50 MHz
  rst_n     in   1          reset, synchronous, active-low
  value_i   in   4*DIGITS   nibble k (bits 4k+3:4k) = digit k, digit 0 rightmost
  load_i    in   1          one-cycle strobe, capture value_i
  blank_i   in   1          leading-zero blanking enable
  en_i      in   DIGITS     per-digit enable mask, 1 = digit may light
  hex_o     out  7          segments {g,f,e,d,c,b,a}, active-low
  hex_on_o  out  DIGITS     digit select, active-low, at most one bit 0
  frame_o   out  1          one-cycle pulse at each frame start
REQ-003 The single clock SHALL be clk_50m; reset SHALL be rst_n, synchronous and active-low.

Function
REQ-004 Nibble-to-segment map SHALL be (hex value -> hex_o): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E.
REQ-005 Block SHALL hold registers: pending[4*DIGITS], pend_vld, shadow[4*DIGITS], state {GUARD, ON}, idx (clog2(DIGITS), min 1 bit), cnt (sized for max(DIV,GUARD)).
REQ-006 load_i=1 SHALL write value_i to pending and set pend_vld; back-to-back loads within a frame: last one wins.
REQ-007 Display SHALL read only shadow; shadow SHALL change only at a frame boundary (no tearing).
REQ-008 GUARD: hex_on_o all 1, hex_o 7F; lasts GUARD cycles (cnt 0..GUARD-1), then ON, cnt cleared.
REQ-009 ON: lasts DIV cycles (cnt 0..DIV-1), then GUARD with idx+1; idx DIGITS-1 wraps to 0.
REQ-010 Frame boundary = ON->GUARD transition with idx DIGITS-1 -> 0; on that edge, if pend_vld, shadow <= pending and pend_vld cleared; frame_o=1 for the first GUARD cycle of idx 0 only.
REQ-011 load_i on the boundary cycle SHALL update pending and leave pend_vld=1; shadow takes the pre-edge pending; new value applies next frame.
REQ-012 Digit k is blanked iff en_i[k]=0, or blank_i=1 and k!=0 and shadow nibbles k..DIGITS-1 are all zero.
REQ-013 In ON for idx k: unblanked -> hex_on_o[k]=0, others 1, hex_o = map(shadow nibble k); blanked -> hex_on_o all 1, hex_o 7F; slot timing unchanged.
REQ-014 hex_o, hex_on_o, frame_o SHALL be registered; values belong to the state held in the same cycle, no combinational input-to-output path.
REQ-015 en_i and blank_i are sampled every cycle, effect visible next cycle, no frame-boundary delay.
REQ-016 Digit 0 SHALL never be blanked by blank_i; value all-zero with blank_i=1 shows single "0".
REQ-017 Slot period SHALL be GUARD+DIV cycles; frame period DIGITS*(GUARD+DIV) cycles, constant under all inputs.

Reset
REQ-018 rst_n=0 at a clock edge SHALL set state=GUARD, idx=0, cnt=0, shadow=0, pending=0, pend_vld=0, hex_o=7F, hex_on_o all 1, frame_o=0.
REQ-019 Reset mid-slot or mid-frame SHALL abandon the frame; a pending load is discarded.
REQ-020 First cycle after release SHALL be GUARD cnt=0 idx=0 with frame_o=1; first ON starts GUARD cycles after release.

Verification (DIGITS=4, DIV=4, GUARD=2: slot 6, frame 24 cycles)
REQ-021 Reset release, no load, blank_i=0, en_i=F -> all four digits show 40 in turn; hex_on_o E,D,B,7 each 4 cycles, 2 off cycles between; frame_o every 24 cycles.
REQ-022 load_i with value_i=0x12AF mid-frame -> current frame keeps old digits; from next frame digit0=0E, digit1=08, digit2=24, digit3=79.
REQ-023 value 0x0050, blank_i=1 -> digits 3 and 2 dark (hex_on_o stays F in their slots), digit1=12, digit0=40; value 0x0000 -> only digit0 shows 40.
REQ-024 Two loads in one frame (0x1111 then 0x2222), plus a load of 0x3333 on the boundary cycle -> next frame shows 2222, frame after shows 3333.
REQ-025 en_i=4'b1010 -> only slots 1 and 3 light; rst_n=0 for one cycle during a slot -> outputs 7F/F next cycle, shadow 0, restart at idx 0 with frame_o.

Source files
------------

// File: rtl/hex_scan_display.sv
// -----------------------------------------------------------------------------
// hex_scan_display
//
// Time-multiplexed driver for a row of common-anode 7-segment digits. Each
// digit gets a slot of GUARD all-off cycles (anti-ghosting) followed by DIV
// lit cycles; the slots repeat with a fixed frame period of
// DIGITS*(GUARD+DIV) cycles regardless of input activity.
//
// A loaded value is parked in a pending buffer and copied into the display
// shadow only at a frame boundary, so a frame never shows a mix of old and
// new digits.
//
// Ports
//   clk_50m   in   1          system clock
//   rst_n     in   1          synchronous active-low reset
//   value_i   in   4*DIGITS   nibble k = digit k, digit 0 rightmost
//   load_i    in   1          one-cycle strobe, capture value_i
//   blank_i   in   1          leading-zero blanking enable
//   en_i      in   DIGITS     per-digit enable mask, 1 = digit may light
//   hex_o     out  7          segments {g,f,e,d,c,b,a}, active-low
//   hex_on_o  out  DIGITS     digit select, active-low, at most one bit 0
//   frame_o   out  1          one-cycle pulse on the first cycle of a frame
// -----------------------------------------------------------------------------
module hex_scan_display #(
    parameter int DIGITS = 8,      // digits scanned (1..8)
    parameter int DIV    = 50000,  // lit cycles per slot (>=1)
    parameter int GUARD  = 16      // all-off cycles before each slot (>=1)
) (
    input  logic                  clk_50m,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic                  load_i,
    input  logic                  blank_i,
    input  logic [DIGITS-1:0]     en_i,
    output logic [6:0]            hex_o,
    output logic [DIGITS-1:0]     hex_on_o,
    output logic                  frame_o
);

    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_MAX = (DIV > GUARD) ? DIV : GUARD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [6:0]       SEG_OFF  = 7'h7F;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    // Hex nibble to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_map(input logic [3:0] nib);
        case (nib)
            4'h0: seg_map = 7'h40;
            4'h1: seg_map = 7'h79;
            4'h2: seg_map = 7'h24;
            4'h3: seg_map = 7'h30;
            4'h4: seg_map = 7'h19;
            4'h5: seg_map = 7'h12;
            4'h6: seg_map = 7'h02;
            4'h7: seg_map = 7'h78;
            4'h8: seg_map = 7'h00;
            4'h9: seg_map = 7'h10;
            4'hA: seg_map = 7'h08;
            4'hB: seg_map = 7'h03;
            4'hC: seg_map = 7'h46;
            4'hD: seg_map = 7'h21;
            4'hE: seg_map = 7'h06;
            default: seg_map = 7'h0E;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_cnt;
    // Cleared by reset so the first cycle after release is a fresh frame
    // start (GUARD, cnt 0, idx 0) that also raises frame_o.
    logic                 r_run;
    logic [4*DIGITS-1:0]  r_pending;
    logic                 r_pend_vld;
    logic [4*DIGITS-1:0]  r_shadow;
    logic [6:0]           r_hex;
    logic [DIGITS-1:0]    r_hex_on;
    logic                 r_frame;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_boundary;
    logic                 w_frame_nxt;
    logic [DIGITS-1:0]    w_zero_from;  // bit k: shadow nibbles k..DIGITS-1 all zero
    logic [DIGITS-1:0]    w_dark;       // bit k: digit k must stay unlit
    logic [6:0]           w_hex_nxt;
    logic [DIGITS-1:0]    w_hex_on_nxt;

    // -------------------------------------------------------------------------
    // Process 1: state register and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    // NOTE: the value buffers are plain flops, not RAM, so resetting them is
    // cheap and guarantees a reset discards any half-finished load.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            r_state    <= ST_GUARD;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_run      <= 1'b0;
            r_pending  <= '0;
            r_pend_vld <= 1'b0;
            r_shadow   <= '0;
            r_hex      <= SEG_OFF;
            r_hex_on   <= '1;
            r_frame    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_run   <= 1'b1;

            // A load on the boundary cycle wins over the clear, so it stays
            // pending for the following frame while the shadow takes the
            // pre-edge value below.
            if (load_i) begin
                r_pending  <= value_i;
                r_pend_vld <= 1'b1;
            end else if (w_boundary) begin
                r_pend_vld <= 1'b0;
            end

            if (w_boundary && r_pend_vld) begin
                r_shadow <= r_pending;
            end

            // Outputs are computed from the next state so they line up with
            // the state held in the same cycle.
            r_hex    <= w_hex_nxt;
            r_hex_on <= w_hex_on_nxt;
            r_frame  <= w_frame_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Process 2: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default at the top of the block, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_boundary  = 1'b0;
        w_frame_nxt = 1'b0;

        if (!r_run) begin
            w_state_nxt = ST_GUARD;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_frame_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_GUARD: begin
                    if (r_cnt == GRD_LAST) begin
                        w_state_nxt = ST_ON;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin  // ST_ON
                    if (r_cnt == DIV_LAST) begin
                        w_state_nxt = ST_GUARD;
                        w_cnt_nxt   = '0;
                        if (r_idx == IDX_LAST) begin
                            w_idx_nxt   = '0;
                            w_boundary  = 1'b1;
                            w_frame_nxt = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Process 3: output logic (registered in process 1)
    // -------------------------------------------------------------------------
    // Leading-zero detection scans from the most significant digit down.
    always_comb begin
        logic v_all_zero;
        v_all_zero  = 1'b1;
        w_zero_from = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            v_all_zero     = v_all_zero && (r_shadow[4*k +: 4] == 4'h0);
            w_zero_from[k] = v_all_zero;
        end
    end

    // Digit 0 is exempt from leading-zero blanking so an all-zero value
    // still shows a single "0".
    always_comb begin
        w_dark = '0;
        for (int k = 0; k < DIGITS; k++) begin
            w_dark[k] = !en_i[k] || (blank_i && (k != 0) && w_zero_from[k]);
        end
    end

    always_comb begin
        w_hex_nxt    = SEG_OFF;
        w_hex_on_nxt = '1;
        if (w_state_nxt == ST_ON && !w_dark[w_idx_nxt]) begin
            w_hex_on_nxt[w_idx_nxt] = 1'b0;
            w_hex_nxt               = seg_map(r_shadow[4*int'(w_idx_nxt) +: 4]);
        end
    end

    assign hex_o    = r_hex;
    assign hex_on_o = r_hex_on;
    assign frame_o  = r_frame;

endmodule

// File: tb/tb_hex_scan_display.sv
// -----------------------------------------------------------------------------
// tb_hex_scan_display
//
// Self-checking bench for hex_scan_display with DIGITS=4, DIV=4, GUARD=2
// (slot 6 cycles, frame 24 cycles). Each frame is checked cycle by cycle
// against hand-computed per-digit segment codes; 7F in the table means the
// digit must stay dark for its whole slot.
// -----------------------------------------------------------------------------
module tb_hex_scan_display;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int GUARD  = 2;
    localparam int SLOT   = GUARD + DIV;
    localparam int FRAME  = DIGITS * SLOT;

    typedef logic [3:0][6:0] segs_t;  // [k] = expected code for digit k

    typedef struct {
        logic [15:0] value;
        logic        blank;
        logic [3:0]  en;
        segs_t       segs;
    } vec_t;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic [15:0] value_i;
    logic        load_i;
    logic        blank_i;
    logic [3:0]  en_i;
    logic [6:0]  hex_o;
    logic [3:0]  hex_on_o;
    logic        frame_o;

    int n_vec = 0;
    int n_err = 0;

    hex_scan_display #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .GUARD  (GUARD)
    ) dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .value_i  (value_i),
        .load_i   (load_i),
        .blank_i  (blank_i),
        .en_i     (en_i),
        .hex_o    (hex_o),
        .hex_on_o (hex_on_o),
        .frame_o  (frame_o)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic check(input string name, input int cyc,
                         input logic [6:0] act, input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Compare all outputs for frame cycle c given the digits the frame shows.
    task automatic check_cycle(input int c, input segs_t exp);
        int         s;
        logic [6:0] e_hex;
        logic [3:0] e_on;
        s = c / SLOT;
        if ((c % SLOT) < GUARD) begin
            e_hex = 7'h7F;
            e_on  = 4'hF;
        end else begin
            e_hex = exp[s];
            e_on  = (e_hex == 7'h7F) ? 4'hF : ~(4'b0001 << s);
        end
        check("frame_o",  c, {6'b0, frame_o},  {6'b0, (c == 0)});
        check("hex_o",    c, hex_o,            e_hex);
        check("hex_on_o", c, {3'b0, hex_on_o}, {3'b0, e_on});
    endtask

    // Check one frame starting at its first cycle. Up to three loads are
    // issued at cycles l0/l1/l2 (-1 = none). blank/en for the next frame are
    // applied on the last cycle. Returns without advancing once cycle
    // stop_at has been checked.
    task automatic check_frame(input segs_t exp,
                               input int l0, input logic [15:0] v0,
                               input int l1, input logic [15:0] v1,
                               input int l2, input logic [15:0] v2,
                               input int stop_at,
                               input logic nb, input logic [3:0] nen);
        for (int c = 0; c < FRAME; c++) begin
            check_cycle(c, exp);
            if (c == stop_at) return;
            load_i = 1'b0;
            if (c == l0) begin load_i = 1'b1; value_i = v0; end
            if (c == l1) begin load_i = 1'b1; value_i = v1; end
            if (c == l2) begin load_i = 1'b1; value_i = v2; end
            if (c == FRAME - 1) begin
                blank_i = nb;
                en_i    = nen;
            end
            tick();
        end
        load_i = 1'b0;
    endtask

    vec_t  vecs[6];
    segs_t prev;

    localparam segs_t ALL0 = {7'h40, 7'h40, 7'h40, 7'h40};
    localparam segs_t ALL2 = {7'h24, 7'h24, 7'h24, 7'h24};
    localparam segs_t ALL3 = {7'h30, 7'h30, 7'h30, 7'h30};

    initial begin
        //            value     blank  en       digit3 digit2 digit1 digit0
        vecs[0] = '{16'h12AF, 1'b0, 4'hF,    {7'h79, 7'h24, 7'h08, 7'h0E}};
        vecs[1] = '{16'h0050, 1'b1, 4'hF,    {7'h7F, 7'h7F, 7'h12, 7'h40}};
        vecs[2] = '{16'h0000, 1'b1, 4'hF,    {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{16'h1234, 1'b0, 4'b1010, {7'h79, 7'h7F, 7'h30, 7'h7F}};
        vecs[4] = '{16'h0800, 1'b1, 4'hF,    {7'h7F, 7'h00, 7'h40, 7'h40}};
        vecs[5] = '{16'hF00F, 1'b1, 4'b0111, {7'h7F, 7'h40, 7'h40, 7'h0E}};

        rst_n   = 1'b0;
        value_i = '0;
        load_i  = 1'b0;
        blank_i = 1'b0;
        en_i    = 4'hF;
        repeat (3) tick();
        check("rst_hex",    -1, hex_o,            7'h7F);
        check("rst_hex_on", -1, {3'b0, hex_on_o}, 7'h0F);
        check("rst_frame",  -1, {6'b0, frame_o},  7'h00);

        // First cycle after release is the start of frame 0.
        rst_n = 1'b1;
        tick();

        // Each vector is loaded mid-frame while the previous contents keep
        // showing; it must appear from the next frame on.
        prev = ALL0;
        foreach (vecs[i]) begin
            check_frame(prev, 8, vecs[i].value, -1, 16'h0, -1, 16'h0,
                        FRAME, vecs[i].blank, vecs[i].en);
            prev = vecs[i].segs;
        end

        // Two loads in a frame plus one on the boundary cycle.
        check_frame(prev, 3, 16'h1111, 10, 16'h2222, FRAME - 1, 16'h3333,
                    FRAME, 1'b0, 4'hF);
        check_frame(ALL2, -1, 16'h0, -1, 16'h0, -1, 16'h0, FRAME, 1'b0, 4'hF);
        check_frame(ALL3, -1, 16'h0, -1, 16'h0, -1, 16'h0, FRAME, 1'b0, 4'hF);

        // Reset for one cycle in the middle of slot 2 with a load pending.
        check_frame(ALL3, 9, 16'h4444, -1, 16'h0, -1, 16'h0, 15, 1'b0, 4'hF);
        load_i = 1'b0;
        rst_n  = 1'b0;
        tick();
        check("mid_rst_hex",    -1, hex_o,            7'h7F);
        check("mid_rst_hex_on", -1, {3'b0, hex_on_o}, 7'h0F);
        check("mid_rst_frame",  -1, {6'b0, frame_o},  7'h00);
        rst_n = 1'b1;
        tick();
        // Shadow cleared and the pending 4444 discarded: two frames of "0".
        check_frame(ALL0, -1, 16'h0, -1, 16'h0, -1, 16'h0, FRAME, 1'b0, 4'hF);
        check_frame(ALL0, -1, 16'h0, -1, 16'h0, -1, 16'h0, FRAME, 1'b0, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
